tp_accel_arbiter: RTL and testbench

//  Two-requester arbiter for the transpose accelerator's custom-instruction interface.
//  - Sits between two instruction issuers (e.g. a CPU core and a DMA/sequencer) and the single

---
 rtl/tp_accel_arbiter.sv | 89 ++++++++
 tb/tb_tp_accel_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/tp_accel_arbiter.sv
// tp_accel_arbiter: round-robin two-requester arbiter with session lock and response routing for the transpose accelerator
module tp_accel_arbiter #(
  parameter int         LOCK_TO = 64,
  parameter logic [6:0] OPC_ACC = 7'b0110011,
  parameter logic [6:0] F7_ACC  = 7'b0000001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0][31:0] req_instr,
  input  logic [1:0][31:0] req_rs1,
  input  logic [1:0][31:0] req_rs2,
  input  logic [1:0][4:0]  req_rd,
  output logic [1:0]       rsp_we,
  output logic [1:0][4:0]  rsp_waddr,
  output logic [1:0][31:0] rsp_wdata,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [31:0]      acc_instr,
  output logic [31:0]      acc_rs1,
  output logic [31:0]      acc_rs2,
  output logic [4:0]       acc_rd,
  input  logic             acc_rd_we,
  input  logic [4:0]       acc_rd_waddr,
  input  logic [31:0]      acc_rd_wdata,
  input  logic             acc_busy,
  output logic             lock_held,
  output logic             lock_owner,
  output logic             rsp_pending
);
  localparam int CW = $clog2(LOCK_TO);
  logic [1:0]    acc_cmd, is_stat, is_resp, is_lk, elig, grant;
  logic          gidx, accept, acquire, own_acc, tout_inc, rr_ptr, rsp_id;
  logic [CW-1:0] idle_cnt;
  // funct3 values 1xx are not commands, so such words are treated as plain
  for (genvar i = 0; i < 2; i++) begin : g_dec
    assign acc_cmd[i] = req_instr[i][6:0] == OPC_ACC && req_instr[i][31:25] == F7_ACC && !req_instr[i][14];
    assign is_stat[i] = acc_cmd[i] && req_instr[i][13:12] == 2'b10;
    assign is_resp[i] = acc_cmd[i] && req_instr[i][13];
    assign is_lk[i]   = acc_cmd[i] && !req_instr[i][13];
    assign elig[i]    = req_valid[i] && acc_ready && !rsp_pending &&
                        (!lock_held || lock_owner == 1'(i) || is_stat[i] || !acc_cmd[i]);
  end
  assign grant     = &elig ? (rr_ptr ? 2'b10 : 2'b01) : elig;
  assign gidx      = grant[1];
  assign accept    = |grant;
  assign req_ready = grant;
  assign acc_valid = accept;
  assign acc_instr = accept ? req_instr[gidx] : '0;
  assign acc_rs1   = accept ? req_rs1[gidx] : '0;
  assign acc_rs2   = accept ? req_rs2[gidx] : '0;
  assign acc_rd    = accept ? req_rd[gidx] : '0;
  assign acquire   = accept && !lock_held && is_lk[gidx];
  assign own_acc   = accept && lock_held && gidx == lock_owner && acc_cmd[gidx];
  assign tout_inc  = lock_held && idle_cnt == CW'(LOCK_TO - 1) && !own_acc && !acc_busy;
  always_comb begin
    rsp_we    = '0;
    rsp_waddr = '0;
    rsp_wdata = '0;
    if (rsp_pending) begin
      rsp_we[rsp_id]    = acc_rd_we;
      rsp_waddr[rsp_id] = acc_rd_waddr;
      rsp_wdata[rsp_id] = acc_rd_wdata;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= 1'b0;
      lock_held   <= 1'b0;
      lock_owner  <= 1'b0;
      idle_cnt    <= '0;
      rsp_pending <= 1'b0;
      rsp_id      <= 1'b0;
    end else begin
      if (accept) rr_ptr <= ~gidx;
      if (acquire) begin
        lock_held  <= 1'b1;
        lock_owner <= gidx;
      end else if (tout_inc) lock_held <= 1'b0;
      idle_cnt <= (acquire || own_acc || acc_busy || tout_inc) ? '0 :
                  lock_held ? idle_cnt + CW'(1) : idle_cnt;
      if (accept && is_resp[gidx]) begin
        rsp_pending <= 1'b1;
        rsp_id      <= gidx;
      end else if (acc_rd_we) rsp_pending <= 1'b0;
    end
  end
endmodule

// File: tb/tb_tp_accel_arbiter.sv
// tb_tp_accel_arbiter: directed-vector bench for tp_accel_arbiter with hand-computed expectations
module tb_tp_accel_arbiter;
  logic             clk = 0, rst = 1;
  logic [1:0]       req_valid = '0, req_ready;
  logic [1:0][31:0] req_instr = '0, req_rs1 = '0, req_rs2 = '0;
  logic [1:0][4:0]  req_rd = '0;
  logic [1:0]       rsp_we;
  logic [1:0][4:0]  rsp_waddr;
  logic [1:0][31:0] rsp_wdata;
  logic             acc_valid, acc_ready = 0, acc_rd_we = 0, acc_busy = 0;
  logic [31:0]      acc_instr, acc_rs1, acc_rs2, acc_rd_wdata = '0;
  logic [4:0]       acc_rd, acc_rd_waddr = '0;
  logic             lock_held, lock_owner, rsp_pending;
  int n_run = 0, n_fail = 0;

  tp_accel_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_instr(req_instr), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .rsp_we(rsp_we), .rsp_waddr(rsp_waddr), .rsp_wdata(rsp_wdata),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_instr(acc_instr),
    .acc_rs1(acc_rs1), .acc_rs2(acc_rs2), .acc_rd(acc_rd),
    .acc_rd_we(acc_rd_we), .acc_rd_waddr(acc_rd_waddr), .acc_rd_wdata(acc_rd_wdata),
    .acc_busy(acc_busy), .lock_held(lock_held), .lock_owner(lock_owner),
    .rsp_pending(rsp_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ai(input logic [2:0] f3, input logic [4:0] rd);
    return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  initial begin
    tick(); tick();
    check("rst_lock", lock_held, 0);
    check("rst_pend", rsp_pending, 0);
    check("rst_valid", acc_valid, 0);
    check("rst_we", rsp_we, 0);
    rst = 0;
    // both AWR while unlocked: r0 wins and takes the lock
    acc_ready = 1;
    req_valid = 2'b11; req_instr[0] = ai(3'b000, 5'd1); req_instr[1] = ai(3'b000, 5'd2);
    req_rs1[0] = 32'h1111; req_rs1[1] = 32'h2222;
    #1;
    check("awr_grant", req_ready, 2'b01);
    check("awr_valid", acc_valid, 1);
    check("awr_instr", acc_instr, ai(3'b000, 5'd1));
    check("awr_rs1", acc_rs1, 32'h1111);
    tick();
    check("awr_held", lock_held, 1);
    check("awr_owner", lock_owner, 0);
    req_valid = 2'b10;
    #1;
    check("r1_blocked", req_ready, 2'b00);
    // r0 STAT rd=5 while r1 AWR still waits
    req_valid = 2'b11; req_instr[0] = ai(3'b010, 5'd5); req_rd[0] = 5'd5;
    #1;
    check("stat0_grant", req_ready, 2'b01);
    check("stat0_rd", acc_rd, 5);
    tick();
    check("stat0_pend", rsp_pending, 1);
    req_valid = 2'b10;
    #1;
    check("pend_block", req_ready, 2'b00);
    acc_rd_we = 1; acc_rd_waddr = 5'd5; acc_rd_wdata = 32'd2;
    #1;
    check("stat0_we", rsp_we, 2'b01);
    check("stat0_waddr", rsp_waddr[0], 5);
    check("stat0_wdata", rsp_wdata[0], 2);
    check("stat0_other", rsp_wdata[1], 0);
    tick();
    acc_rd_we = 0;
    check("stat0_clr", rsp_pending, 0);
    // non-owner STAT is allowed through the lock
    req_valid = 2'b10; req_instr[1] = ai(3'b010, 5'd7); req_rd[1] = 5'd7;
    #1;
    check("stat1_grant", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    acc_rd_we = 1; acc_rd_waddr = 5'd7; acc_rd_wdata = 32'hABCD;
    #1;
    check("stat1_we", rsp_we, 2'b10);
    check("stat1_wdata", rsp_wdata[1], 32'hABCD);
    check("stat1_waddr", rsp_waddr[1], 7);
    check("stat1_oaddr", rsp_waddr[0], 0);
    tick();
    acc_rd_we = 0;
    check("stat1_owner", lock_owner, 0);
    check("stat1_held", lock_held, 1);
    // r0 BRD, acc_ready low for 3 cycles, r1 waits until after the writeback
    req_valid = 2'b01; req_instr[0] = ai(3'b011, 5'd3);
    #1;
    check("brd_grant", req_ready, 2'b01);
    tick();
    req_valid = 2'b10; acc_ready = 0;
    tick(); tick(); tick();
    check("brd_nordy", req_ready, 2'b00);
    acc_ready = 1;
    #1;
    check("brd_pend", req_ready, 2'b00);
    acc_rd_we = 1; acc_rd_waddr = 5'd3; acc_rd_wdata = 32'h55;
    #1;
    check("brd_we", rsp_we, 2'b01);
    check("brd_same", req_ready, 2'b00);
    tick();
    acc_rd_we = 0;
    #1;
    check("brd_next", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    acc_rd_we = 1; acc_rd_wdata = 32'h9;
    #1;
    check("brd_r1we", rsp_we, 2'b10);
    tick();
    acc_rd_we = 0;
    // lock timeout: owner AWR then 64 idle edges
    req_valid = 2'b01; req_instr[0] = ai(3'b000, 5'd1);
    tick();
    req_valid = 2'b00;
    repeat (62) tick();
    check("to_62", lock_held, 1);
    tick();
    check("to_63", lock_held, 1);
    tick();
    check("to_64", lock_held, 0);
    req_valid = 2'b10; req_instr[1] = ai(3'b000, 5'd2);
    #1;
    check("to_r1grant", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    check("to_r1held", lock_held, 1);
    check("to_r1owner", lock_owner, 1);
    // reset mid-session, then plain-instruction streaming alternates
    rst = 1;
    tick();
    rst = 0;
    check("rst2_lock", lock_held, 0);
    req_valid = 2'b11; req_instr[0] = 32'h00100093; req_instr[1] = 32'h00200113;
    acc_rd_we = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_grant", req_ready, (k % 2) ? 2'b10 : 2'b01);
      check("rr_instr", acc_instr, (k % 2) ? 32'h00200113 : 32'h00100093);
      check("rr_nowe", rsp_we, 2'b00);
      tick();
    end
    acc_rd_we = 0; req_valid = 2'b00;
    check("rr_lock", lock_held, 0);
    check("rr_pend", rsp_pending, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
